// File: rtl/l1_ahb_mtx_out_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : l1_ahb_mtx_out_stage                                       |
// | Description : L1 AHB bus-matrix output stage. Arbitrates up to three     |
// |               input-stage requests onto one AHB-Lite master port and     |
// |               returns per-port active/readyout plus shared resp/rdata.   |
// |               Default arbitration is round-robin; defining the macro     |
// |               L1_AHB_MTX_FIXED_PRI_EN selects fixed priority 1 > 2 > 3.  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module l1_ahb_mtx_out_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              sel_op1,
  input  logic              sel_op2,
  input  logic              sel_op3,
  input  logic [ADDR_W-1:0] addr_op1,
  input  logic [ADDR_W-1:0] addr_op2,
  input  logic [ADDR_W-1:0] addr_op3,
  input  logic [1:0]        trans_op1,
  input  logic [1:0]        trans_op2,
  input  logic [1:0]        trans_op3,
  input  logic              write_op1,
  input  logic              write_op2,
  input  logic              write_op3,
  input  logic [2:0]        size_op1,
  input  logic [2:0]        size_op2,
  input  logic [2:0]        size_op3,
  input  logic [2:0]        burst_op1,
  input  logic [2:0]        burst_op2,
  input  logic [2:0]        burst_op3,
  input  logic              mastlock_op1,
  input  logic              mastlock_op2,
  input  logic              mastlock_op3,
  input  logic [DATA_W-1:0] wdata_op1,
  input  logic [DATA_W-1:0] wdata_op2,
  input  logic [DATA_W-1:0] wdata_op3,
  input  logic              HREADYM,
  input  logic [1:0]        HRESPM,
  input  logic [DATA_W-1:0] HRDATAM,
  output logic              HSELM,
  output logic [ADDR_W-1:0] HADDRM,
  output logic [1:0]        HTRANSM,
  output logic              HWRITEM,
  output logic [2:0]        HSIZEM,
  output logic [2:0]        HBURSTM,
  output logic              HMASTLOCKM,
  output logic [DATA_W-1:0] HWDATAM,
  output logic              active_op1,
  output logic              active_op2,
  output logic              active_op3,
  output logic              readyout_op1,
  output logic              readyout_op2,
  output logic              readyout_op3,
  output logic [1:0]        resp_op,
  output logic [DATA_W-1:0] rdata_op
);

  localparam logic [1:0] c_none  = 2'd0;
  localparam logic [1:0] c_port1 = 2'd1;
  localparam logic [1:0] c_port2 = 2'd2;
  localparam logic [1:0] c_port3 = 2'd3;
  localparam logic [1:0] c_busy  = 2'b01;
  localparam logic [1:0] c_seq   = 2'b11;

  logic [1:0] r_addr_port;
  logic [1:0] r_data_port;
  logic [1:0] r_last_port;
  logic [3:1] w_req;
  logic       w_hold;
  logic [1:0] w_arb_grant;
  logic [1:0] w_next_grant;

  // A port requests when its decoder selects us with a NONSEQ or SEQ transfer
  assign w_req = {sel_op3 & trans_op3[1], sel_op2 & trans_op2[1], sel_op1 & trans_op1[1]};

  // Owner keeps the bus through locked sequences and the middle of bursts
  assign w_hold = (r_addr_port != c_none) &&
                  (HMASTLOCKM || (HTRANSM == c_seq) || (HTRANSM == c_busy));

  // Arbitration among current requesters when the owner does not hold
  always_comb begin
    w_arb_grant = c_none;
`ifdef L1_AHB_MTX_FIXED_PRI_EN
    if      (w_req[1]) w_arb_grant = c_port1;
    else if (w_req[2]) w_arb_grant = c_port2;
    else if (w_req[3]) w_arb_grant = c_port3;
`else
    case (r_last_port)
      c_port1: begin
        if      (w_req[2]) w_arb_grant = c_port2;
        else if (w_req[3]) w_arb_grant = c_port3;
        else if (w_req[1]) w_arb_grant = c_port1;
      end
      c_port2: begin
        if      (w_req[3]) w_arb_grant = c_port3;
        else if (w_req[1]) w_arb_grant = c_port1;
        else if (w_req[2]) w_arb_grant = c_port2;
      end
      default: begin
        if      (w_req[1]) w_arb_grant = c_port1;
        else if (w_req[2]) w_arb_grant = c_port2;
        else if (w_req[3]) w_arb_grant = c_port3;
      end
    endcase
`endif
  end

  assign w_next_grant = w_hold ? r_addr_port : w_arb_grant;

  // Grant, data-phase owner and round-robin pointer advance only when the slave is ready
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_addr_port <= c_none;
      r_data_port <= c_none;
      r_last_port <= c_port3;
    end else if (HREADYM) begin
      r_addr_port <= w_next_grant;
      r_data_port <= HTRANSM[1] ? r_addr_port : c_none;
`ifndef L1_AHB_MTX_FIXED_PRI_EN
      if ((w_next_grant != c_none) && (w_next_grant != r_addr_port))
        r_last_port <= w_next_grant;
`endif
    end
  end

  // Address-phase mux of the owning port; all zero when nobody owns the bus
  always_comb begin
    HSELM      = 1'b0;
    HADDRM     = '0;
    HTRANSM    = 2'b00;
    HWRITEM    = 1'b0;
    HSIZEM     = 3'd0;
    HBURSTM    = 3'd0;
    HMASTLOCKM = 1'b0;
    case (r_addr_port)
      c_port1: begin
        HSELM = sel_op1; HADDRM = addr_op1; HTRANSM = trans_op1; HWRITEM = write_op1;
        HSIZEM = size_op1; HBURSTM = burst_op1; HMASTLOCKM = mastlock_op1;
      end
      c_port2: begin
        HSELM = sel_op2; HADDRM = addr_op2; HTRANSM = trans_op2; HWRITEM = write_op2;
        HSIZEM = size_op2; HBURSTM = burst_op2; HMASTLOCKM = mastlock_op2;
      end
      c_port3: begin
        HSELM = sel_op3; HADDRM = addr_op3; HTRANSM = trans_op3; HWRITEM = write_op3;
        HSIZEM = size_op3; HBURSTM = burst_op3; HMASTLOCKM = mastlock_op3;
      end
      default: ;
    endcase
  end

  // Write data follows the port that owns the data phase
  always_comb begin
    HWDATAM = '0;
    case (r_data_port)
      c_port1: HWDATAM = wdata_op1;
      c_port2: HWDATAM = wdata_op2;
      c_port3: HWDATAM = wdata_op3;
      default: ;
    endcase
  end

  assign active_op1   = (r_addr_port == c_port1);
  assign active_op2   = (r_addr_port == c_port2);
  assign active_op3   = (r_addr_port == c_port3);
  assign readyout_op1 = (r_data_port == c_port1) ? HREADYM : 1'b1;
  assign readyout_op2 = (r_data_port == c_port2) ? HREADYM : 1'b1;
  assign readyout_op3 = (r_data_port == c_port3) ? HREADYM : 1'b1;
  assign resp_op      = HRESPM;
  assign rdata_op     = HRDATAM;

endmodule
`default_nettype wire

// File: tb/tb_l1_ahb_mtx_out_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_l1_ahb_mtx_out_stage                                    |
// | Description : Directed self-checking bench for l1_ahb_mtx_out_stage.     |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_l1_ahb_mtx_out_stage;

  localparam logic [1:0] c_idle   = 2'b00;
  localparam logic [1:0] c_busy   = 2'b01;
  localparam logic [1:0] c_nonseq = 2'b10;
  localparam logic [1:0] c_seq    = 2'b11;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        sel      [1:3];
  logic [31:0] addr     [1:3];
  logic [1:0]  trans    [1:3];
  logic        write    [1:3];
  logic [2:0]  size     [1:3];
  logic [2:0]  burst    [1:3];
  logic        mastlock [1:3];
  logic [31:0] wdata    [1:3];
  logic        HREADYM;
  logic [1:0]  HRESPM;
  logic [31:0] HRDATAM;

  logic        HSELM, HWRITEM, HMASTLOCKM;
  logic [31:0] HADDRM, HWDATAM, rdata_op;
  logic [1:0]  HTRANSM, resp_op;
  logic [2:0]  HSIZEM, HBURSTM;
  logic        act1, act2, act3, rdy1, rdy2, rdy3;

  int total = 0;
  int bad   = 0;
  int exp_p [0:4];

  always #5 HCLK = ~HCLK;

  l1_ahb_mtx_out_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .sel_op1(sel[1]), .sel_op2(sel[2]), .sel_op3(sel[3]),
    .addr_op1(addr[1]), .addr_op2(addr[2]), .addr_op3(addr[3]),
    .trans_op1(trans[1]), .trans_op2(trans[2]), .trans_op3(trans[3]),
    .write_op1(write[1]), .write_op2(write[2]), .write_op3(write[3]),
    .size_op1(size[1]), .size_op2(size[2]), .size_op3(size[3]),
    .burst_op1(burst[1]), .burst_op2(burst[2]), .burst_op3(burst[3]),
    .mastlock_op1(mastlock[1]), .mastlock_op2(mastlock[2]), .mastlock_op3(mastlock[3]),
    .wdata_op1(wdata[1]), .wdata_op2(wdata[2]), .wdata_op3(wdata[3]),
    .HREADYM(HREADYM), .HRESPM(HRESPM), .HRDATAM(HRDATAM),
    .HSELM(HSELM), .HADDRM(HADDRM), .HTRANSM(HTRANSM), .HWRITEM(HWRITEM),
    .HSIZEM(HSIZEM), .HBURSTM(HBURSTM), .HMASTLOCKM(HMASTLOCKM), .HWDATAM(HWDATAM),
    .active_op1(act1), .active_op2(act2), .active_op3(act3),
    .readyout_op1(rdy1), .readyout_op2(rdy2), .readyout_op3(rdy3),
    .resp_op(resp_op), .rdata_op(rdata_op)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive(input int n, input logic s, input logic [1:0] t, input logic [31:0] a,
                       input logic w, input logic [2:0] b, input logic l, input logic [31:0] d);
    sel[n] = s; trans[n] = t; addr[n] = a; write[n] = w;
    size[n] = 3'd2; burst[n] = b; mastlock[n] = l; wdata[n] = d;
  endtask

  task automatic idle_all();
    for (int n = 1; n <= 3; n++) drive(n, 1'b0, c_idle, 32'h0, 1'b0, 3'd0, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    idle_all();
    HREADYM = 1'b1;
    HRESET  = 1'b1;
    cyc();
    HRESET  = 1'b0;
  endtask

  initial begin
    HRESET = 1'b1; HREADYM = 1'b1; HRESPM = 2'b00; HRDATAM = 32'h0;
    idle_all();
    cyc(); cyc();
    HRESET = 1'b0;
    #1;
    // reset and idle
    chk("rst_hsel",   HSELM, 1'b0);
    chk("rst_htrans", HTRANSM, 2'b00);
    chk("rst_active", {act3, act2, act1}, 3'b000);
    chk("rst_ready",  {rdy3, rdy2, rdy1}, 3'b111);
    chk("rst_haddr",  HADDRM, 32'h0);
    chk("rst_hwdata", HWDATAM, 32'h0);
    HRESPM = 2'b01; HRDATAM = 32'hDEADBEEF;
    #1;
    chk("pass_resp",  resp_op, 2'b01);
    chk("pass_rdata", rdata_op, 32'hDEADBEEF);
    HRESPM = 2'b00; HRDATAM = 32'h0;

    // single write from port 2
    drive(2, 1'b1, c_nonseq, 32'h20000010, 1'b1, 3'd0, 1'b0, 32'hA5A50001);
    cyc(); #1;
    chk("wr_haddr",  HADDRM, 32'h20000010);
    chk("wr_active", {act3, act2, act1}, 3'b010);
    chk("wr_htrans", HTRANSM, c_nonseq);
    chk("wr_hwrite", HWRITEM, 1'b1);
    chk("wr_hsize",  HSIZEM, 3'd2);
    cyc();
    drive(2, 1'b0, c_idle, 32'h0, 1'b0, 3'd0, 1'b0, 32'hA5A50001);
    HREADYM = 1'b0;
    #1;
    chk("wr_hwdata", HWDATAM, 32'hA5A50001);
    chk("wr_rdy_lo", {rdy3, rdy2, rdy1}, 3'b101);
    HREADYM = 1'b1;
    #1;
    chk("wr_rdy_hi", {rdy3, rdy2, rdy1}, 3'b111);
    cyc(); #1;
    chk("wr_release", {act3, act2, act1}, 3'b000);
    chk("wr_wd_zero", HWDATAM, 32'h0);

    // wait states during a port 2 data phase
    do_reset();
    drive(2, 1'b1, c_nonseq, 32'h20000020, 1'b1, 3'd0, 1'b0, 32'h0000BEEF);
    cyc(); cyc();
    drive(2, 1'b0, c_idle, 32'h0, 1'b0, 3'd0, 1'b0, 32'h0000BEEF);
    HREADYM = 1'b0;
    #1;
    chk("ws1_rdy", {rdy3, rdy2, rdy1}, 3'b101);
    chk("ws1_act", {act3, act2, act1}, 3'b010);
    chk("ws1_wd",  HWDATAM, 32'h0000BEEF);
    cyc();
    drive(1, 1'b1, c_nonseq, 32'h10000080, 1'b0, 3'd0, 1'b0, 32'h0);
    #1;
    chk("ws2_rdy", {rdy3, rdy2, rdy1}, 3'b101);
    chk("ws2_act", {act3, act2, act1}, 3'b010);
    cyc(); #1;
    chk("ws3_rdy", {rdy3, rdy2, rdy1}, 3'b101);
    chk("ws3_act", {act3, act2, act1}, 3'b010);
    HREADYM = 1'b1;
    #1;
    chk("ws_end_rdy", {rdy3, rdy2, rdy1}, 3'b111);
    cyc(); #1;
    chk("ws_next_act", {act3, act2, act1}, 3'b001);
    chk("ws_next_wd",  HWDATAM, 32'h0);

    // three-way contention
`ifdef L1_AHB_MTX_FIXED_PRI_EN
    exp_p = '{1, 1, 1, 1, 1};
`else
    exp_p = '{1, 2, 3, 1, 2};
`endif
    do_reset();
    for (int n = 1; n <= 3; n++)
      drive(n, 1'b1, c_nonseq, 32'h10000000 + n, 1'b1, 3'd0, 1'b0, 32'hD0000000 + n);
    for (int i = 0; i < 5; i++) begin
      cyc(); #1;
      chk("arb_active", {act3, act2, act1}, 3'b001 << (exp_p[i] - 1));
      chk("arb_haddr",  HADDRM, 32'h10000000 + exp_p[i]);
      chk("arb_hwdata", HWDATAM, (i == 0) ? 32'h0 : 32'hD0000000 + exp_p[i-1]);
    end

    // reset in the middle of a stalled transfer
    HREADYM = 1'b0;
    HRESET  = 1'b1;
    cyc();
    HRESET  = 1'b0;
    #1;
    chk("midrst_act",  {act3, act2, act1}, 3'b000);
    chk("midrst_rdy",  {rdy3, rdy2, rdy1}, 3'b111);
    chk("midrst_hsel", HSELM, 1'b0);
    chk("midrst_wd",   HWDATAM, 32'h0);

    // INCR4 burst from port 1 with one BUSY while port 3 requests
    do_reset();
    drive(1, 1'b1, c_nonseq, 32'h100, 1'b1, 3'd3, 1'b0, 32'hB0);
    cyc(); #1;
    chk("bst_act0",   {act3, act2, act1}, 3'b001);
    chk("bst_htrans", HTRANSM, c_nonseq);
    chk("bst_hburst", HBURSTM, 3'd3);
    cyc();
    drive(1, 1'b1, c_seq, 32'h104, 1'b1, 3'd3, 1'b0, 32'hB1);
    drive(3, 1'b1, c_nonseq, 32'h300, 1'b0, 3'd0, 1'b0, 32'h33);
    #1;
    chk("bst_act1", {act3, act2, act1}, 3'b001);
    chk("bst_wd1",  HWDATAM, 32'hB1);
    cyc();
    drive(1, 1'b1, c_busy, 32'h108, 1'b1, 3'd3, 1'b0, 32'hB1);
    #1;
    chk("bst_act_busy", {act3, act2, act1}, 3'b001);
    chk("bst_htrans_b", HTRANSM, c_busy);
    cyc();
    drive(1, 1'b1, c_seq, 32'h108, 1'b1, 3'd3, 1'b0, 32'hB2);
    #1;
    chk("bst_act2",   {act3, act2, act1}, 3'b001);
    chk("bst_wd_bsy", HWDATAM, 32'h0);
    cyc();
    drive(1, 1'b1, c_seq, 32'h10C, 1'b1, 3'd3, 1'b0, 32'hB3);
    #1;
    chk("bst_act3",  {act3, act2, act1}, 3'b001);
    chk("bst_addr3", HADDRM, 32'h10C);
    cyc();
    drive(1, 1'b0, c_idle, 32'h0, 1'b0, 3'd0, 1'b0, 32'hB4);
    #1;
    chk("bst_tail_act", {act3, act2, act1}, 3'b001);
    chk("bst_tail_tr",  HTRANSM, c_idle);
    chk("bst_tail_wd",  HWDATAM, 32'hB4);
    cyc(); #1;
    chk("bst_p3_act",  {act3, act2, act1}, 3'b100);
    chk("bst_p3_addr", HADDRM, 32'h300);

    // locked sequence from port 3 while port 1 requests
    do_reset();
    drive(3, 1'b1, c_nonseq, 32'h30000000, 1'b1, 3'd0, 1'b1, 32'h3);
    cyc(); #1;
    chk("lk_act0",  {act3, act2, act1}, 3'b100);
    chk("lk_lock0", HMASTLOCKM, 1'b1);
    drive(1, 1'b1, c_nonseq, 32'h10000040, 1'b0, 3'd0, 1'b0, 32'h0);
    cyc();
    drive(3, 1'b1, c_nonseq, 32'h30000004, 1'b1, 3'd0, 1'b1, 32'h4);
    #1;
    chk("lk_act1",  {act3, act2, act1}, 3'b100);
    chk("lk_addr1", HADDRM, 32'h30000004);
    chk("lk_lock1", HMASTLOCKM, 1'b1);
    cyc();
    drive(3, 1'b0, c_idle, 32'h0, 1'b0, 3'd0, 1'b0, 32'h4);
    #1;
    chk("lk_act2",  {act3, act2, act1}, 3'b100);
    chk("lk_lock2", HMASTLOCKM, 1'b0);
    cyc(); #1;
    chk("lk_p1_act",  {act3, act2, act1}, 3'b001);
    chk("lk_p1_addr", HADDRM, 32'h10000040);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
